// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-stage capture bus and register-file write port
//   M_Valid/M_RegWrite/M_Rw/M_WbSel/M_LoadType  MEM-stage control fields
//   M_AluOut/M_MemData/M_PcLink                 MEM-stage data fields
//   WE/Rw/busW                                  register-file write port
//   W_Valid                                     WB stage holds a real instruction
// master: the pipeline side driving the MEM fields; slave: the MEM/WB stage.
interface mem_wb_stage_if;
  logic        M_Valid;
  logic        M_RegWrite;
  logic [4:0]  M_Rw;
  logic [1:0]  M_WbSel;
  logic [2:0]  M_LoadType;
  logic [31:0] M_AluOut;
  logic [31:0] M_MemData;
  logic [31:0] M_PcLink;
  logic        WE;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic        W_Valid;

  modport master (
    output M_Valid, M_RegWrite, M_Rw, M_WbSel, M_LoadType,
           M_AluOut, M_MemData, M_PcLink,
    input  WE, Rw, busW, W_Valid
  );

  modport slave (
    input  M_Valid, M_RegWrite, M_Rw, M_WbSel, M_LoadType,
           M_AluOut, M_MemData, M_PcLink,
    output WE, Rw, busW, W_Valid
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back select and load alignment.
//   Clk      clock, all state updates on posedge
//   Rst_n    synchronous active-low reset
//   Stall    hold the current occupant
//   Flush    replace the occupant with a bubble (wins over Stall)
//   bus      MEM-stage fields in, register-file write port out
//   Retired  count of instructions leaving WB, wraps modulo 2^CNT_W
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             Flush,
  mem_wb_stage_if.slave    bus,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ALU2 = 2'b11
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_e;

  logic             valid_q,    valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rw_q,       rw_d;
  logic [1:0]       wbsel_q,    wbsel_d;
  logic [2:0]       loadtype_q, loadtype_d;
  logic [31:0]      aluout_q,   aluout_d;
  logic [31:0]      memdata_q,  memdata_d;
  logic [31:0]      pclink_q,   pclink_d;
  logic [CNT_W-1:0] retired_q,  retired_d;

  logic             retire;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_val;

  // Next-state: Flush beats Stall; a Flush also retires a valid occupant.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rw_d       = rw_q;
    wbsel_d    = wbsel_q;
    loadtype_d = loadtype_q;
    aluout_d   = aluout_q;
    memdata_d  = memdata_q;
    pclink_d   = pclink_q;
    retire     = valid_q & (Flush | ~Stall);
    retired_d  = retired_q + CNT_W'(retire);
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rw_d       = '0;
      wbsel_d    = '0;
      loadtype_d = '0;
      aluout_d   = '0;
      memdata_d  = '0;
      pclink_d   = '0;
    end else if (!Stall) begin
      valid_d    = bus.M_Valid;
      regwrite_d = bus.M_RegWrite;
      rw_d       = bus.M_Rw;
      wbsel_d    = bus.M_WbSel;
      loadtype_d = bus.M_LoadType;
      aluout_d   = bus.M_AluOut;
      memdata_d  = bus.M_MemData;
      pclink_d   = bus.M_PcLink;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rw_q       <= '0;
      wbsel_q    <= '0;
      loadtype_q <= '0;
      aluout_q   <= '0;
      memdata_q  <= '0;
      pclink_q   <= '0;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rw_q       <= rw_d;
      wbsel_q    <= wbsel_d;
      loadtype_q <= loadtype_d;
      aluout_q   <= aluout_d;
      memdata_q  <= memdata_d;
      pclink_q   <= pclink_d;
      retired_q  <= retired_d;
    end
  end

  // Big-endian lanes: byte 0 is memdata[31:24]; halfword select uses a[1] only.
  always_comb begin
    ld_byte = 8'h00;
    case (aluout_q[1:0])
      2'd0: ld_byte = memdata_q[31:24];
      2'd1: ld_byte = memdata_q[23:16];
      2'd2: ld_byte = memdata_q[15:8];
      2'd3: ld_byte = memdata_q[7:0];
      default: ld_byte = 8'h00;
    endcase
    ld_half = aluout_q[1] ? memdata_q[15:0] : memdata_q[31:16];

    load_val = memdata_q;
    case (loadtype_q)
      LD_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_val = {24'h000000, ld_byte};
      LD_H:    load_val = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_val = {16'h0000, ld_half};
      default: load_val = memdata_q;
    endcase
  end

  // WE is masked for $0 so the register-file bypass never returns nonzero for $0.
  always_comb begin
    bus.WE      = valid_q & regwrite_q & (rw_q != 5'd0);
    bus.Rw      = rw_q;
    bus.W_Valid = valid_q;
    case (wbsel_q)
      WB_MEM:  bus.busW = load_val;
      WB_LINK: bus.busW = pclink_q;
      default: bus.busW = aluout_q;
    endcase
  end

  assign Retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Flush;
  logic [31:0] Retired;
  logic [3:0]  Retired4;

  mem_wb_stage_if bus();
  mem_wb_stage_if bus4();

  mem_wb_stage #(.CNT_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .bus(bus.slave), .Retired(Retired)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .bus(bus4.slave), .Retired(Retired4)
  );

  assign bus4.M_Valid    = bus.M_Valid;
  assign bus4.M_RegWrite = bus.M_RegWrite;
  assign bus4.M_Rw       = bus.M_Rw;
  assign bus4.M_WbSel    = bus.M_WbSel;
  assign bus4.M_LoadType = bus.M_LoadType;
  assign bus4.M_AluOut   = bus.M_AluOut;
  assign bus4.M_MemData  = bus.M_MemData;
  assign bus4.M_PcLink   = bus.M_PcLink;

  always #5 Clk = ~Clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: contents of the WB slot and the number of retirements.
  logic        m_valid, m_regw;
  logic [4:0]  m_rw;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_mem, m_link;
  logic [31:0] m_ret;

  function automatic logic [31:0] ref_busw();
    int unsigned a, b, h;
    a = int'(m_alu[1:0]);
    if (m_wbsel == 2'b10) return m_link;
    if (m_wbsel != 2'b01) return m_alu;
    b = (m_mem >> (8 * (3 - a))) & 32'hFF;
    h = (m_mem >> (16 * (1 - (a / 2)))) & 32'hFFFF;
    case (m_lt)
      3'd1: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4: return h;
      default: return m_mem;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("WE", {31'd0, bus.WE}, {31'd0, m_valid && m_regw && (m_rw != 0)});
    chk("Rw", {27'd0, bus.Rw}, {27'd0, m_rw});
    chk("busW", bus.busW, ref_busw());
    chk("W_Valid", {31'd0, bus.W_Valid}, {31'd0, m_valid});
    chk("Retired", Retired, m_ret);
    chk("Retired4", {28'd0, Retired4}, m_ret % 16);
  endtask

  task automatic step();
    @(posedge Clk);
    if (!Rst_n) begin
      {m_valid, m_regw, m_rw, m_wbsel, m_lt, m_alu, m_mem, m_link} = '0;
      m_ret = 0;
    end else begin
      if ((Flush || !Stall) && m_valid) m_ret = m_ret + 1;
      if (Flush) begin
        {m_valid, m_regw, m_rw, m_wbsel, m_lt, m_alu, m_mem, m_link} = '0;
      end else if (!Stall) begin
        m_valid = bus.M_Valid;   m_regw = bus.M_RegWrite; m_rw = bus.M_Rw;
        m_wbsel = bus.M_WbSel;   m_lt = bus.M_LoadType;   m_alu = bus.M_AluOut;
        m_mem = bus.M_MemData;   m_link = bus.M_PcLink;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic rg, input logic [4:0] rw,
                       input logic [1:0] ws, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link);
    bus.M_Valid = v;   bus.M_RegWrite = rg; bus.M_Rw = rw; bus.M_WbSel = ws;
    bus.M_LoadType = lt; bus.M_AluOut = alu; bus.M_MemData = mem; bus.M_PcLink = link;
  endtask

  task automatic drive_rand();
    drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom);
  endtask

  logic [2:0]  lt_tab [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd0};
  logic [1:0]  a_tab  [7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
  logic [31:0] e_tab  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F02,
                              32'h000080F1, 32'hFFFF80F1, 32'h80F17F02};
  logic [31:0] ret_hold;

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    drive_rand();
    m_ret = 32'hFFFF_FFFF;
    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin step(); drive_rand(); end
    chk("rst_WE", {31'd0, bus.WE}, 32'd0);
    chk("rst_busW", bus.busW, 32'd0);
    chk("rst_Retired", Retired, 32'd0);

    // First ALU write after reset.
    Rst_n = 1'b1;
    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'h0, 32'h0);
    step();
    chk("alu_WE", {31'd0, bus.WE}, 32'd1);
    chk("alu_busW", bus.busW, 32'h00001234);
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("alu_Retired", Retired, 32'd1);

    // Load alignment table.
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 5'd9, 2'b01, lt_tab[i], {30'h400, a_tab[i]}, 32'h80F17F02, 32'h0);
      step();
      chk("load_busW", bus.busW, e_tab[i]);
    end

    // Write to $0 is suppressed but still retires.
    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    chk("r0_WE", {31'd0, bus.WE}, 32'd0);
    chk("r0_WV", {31'd0, bus.W_Valid}, 32'd1);

    // Stall holds, Stall+Flush bubbles and retires.
    drive(1, 1, 5'd7, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0);
    step();
    ret_hold = m_ret;
    Stall = 1'b1;
    drive_rand();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_Rw", {27'd0, bus.Rw}, 32'd7);
      chk("stall_Retired", Retired, ret_hold);
    end
    Flush = 1'b1;
    step();
    chk("flush_WV", {31'd0, bus.W_Valid}, 32'd0);
    chk("flush_Retired", Retired, ret_hold + 1);
    Stall = 1'b0; Flush = 1'b0;

    // Link select, then a bubble with regwrite set.
    drive(1, 1, 5'd31, 2'b10, 3'd0, 32'h5, 32'h0, 32'h00400010);
    step();
    chk("link_busW", bus.busW, 32'h00400010);
    chk("link_WE", {31'd0, bus.WE}, 32'd1);
    drive(0, 1, 5'd3, 2'b00, 3'd0, 32'h5, 32'h0, 32'h0);
    step();
    ret_hold = m_ret;
    chk("bubble_WE", {31'd0, bus.WE}, 32'd0);
    step();
    chk("bubble_Retired", Retired, ret_hold);

    // Counter wrap on the 4-bit instance.
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 5'(i + 1), 2'b00, 3'd0, 32'(i), 32'h0, 32'h0);
      step();
    end
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("wrap_Retired4", {28'd0, Retired4}, 32'd1);

    // Random traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Rst_n = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register plus write-back select for the 5-stage pipelined CPU. Captures the MEM-stage result on each rising clock edge, selects and load-aligns the write-back value, and drives the write port (WE, Rw, busW) of the register file. It also supports stall and flush, and keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst_n  in  1  reset, synchronous, active-low
- Stall  in  1  hold current contents
- Flush  in  1  load a bubble
- M_Valid  in  1  MEM stage holds a real instruction
- M_RegWrite  in  1  instruction writes a register
- M_Rw  in  5  destination register
- M_WbSel  in  2  00 ALU, 01 memory, 10 link, 11 ALU
- M_LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others lw
- M_AluOut  in  32  ALU result / effective address
- M_MemData  in  32  raw data-memory word
- M_PcLink  in  32  link address for jal/jalr
- WE  out  1  register-file write enable
- Rw  out  5  register-file write address
- busW  out  32  register-file write data
- W_Valid  out  1  WB stage holds a real instruction
- Retired  out  CNT_W  count of instructions leaving WB

## Operation
- Stage register fields: valid, regwrite, rw, wbsel, loadtype, aluout, memdata, pclink.
- Per-posedge update priority:
  - !Rst_n: all fields cleared to 0, Retired=0.
  - else Flush: valid=0, regwrite=0, rw=0. Other fields are don't-care (cleared). Flush beats Stall.
  - else Stall: all fields hold.
  - else: all fields load from M_* inputs.
- Outputs are combinational from registered fields only. There is no path from any M_* input to any output.
  - WE = valid & regwrite & (rw != 0).
    - The register file bypasses busW onto busA/busB whenever Ra==Rw and WE is high.
    - WE must therefore never be 1 with Rw==0, otherwise reads of $0 would return nonzero.
  - Rw = rw.
  - W_Valid = valid.
  - busW is selected by wbsel:
    - ALU: aluout.
    - link: pclink.
    - memory: load-aligned memdata, as below.
- Load alignment is big-endian, with a = aluout[1:0]:
  - lw: memdata, address low bits ignored.
  - lb/lbu: byte index a; byte 0 = memdata[31:24], byte 3 = memdata[7:0]. lb sign-extends, lbu zero-extends.
  - lh/lhu: a[1]=0 selects memdata[31:16], a[1]=1 selects memdata[15:0]. a[0] is ignored; no misalignment trap. lh sign-extends, lhu zero-extends.
- Retired counter:
  - Increments by 1 on each posedge where !Stall & !Flush & valid (current instruction leaves WB).
  - Flush also retires a valid occupant; the increment condition on a Flush edge is Flush & valid.
  - Stall alone never increments.
  - Wraps modulo 2^CNT_W.

## Timing
- Latency: M_* sampled at posedge N. WE/Rw/busW are valid for all of cycle N..N+1. The register file commits at posedge N+1.
- The register file reads on negedge. busW is stable from shortly after posedge, so the same-cycle bypass in the second half-cycle sees a settled value.
- Reset values: WE=0, Rw=0, busW=0 (ALU select of aluout=0), W_Valid=0, Retired=0.
- Reset mid-operation discards the occupant without retiring it.
- Simultaneous cases:
  - Stall & Flush: bubble inserted, occupant retired if valid.
  - Stall held k cycles: outputs constant, WE may stay high. Rewriting the same value is harmless.
- Invalid M_LoadType values (101–111) behave as lw.

## Test plan
- Reset: hold Rst_n=0 two cycles with random M_* → WE=0, Rw=0, busW=0, W_Valid=0, Retired=0. Release, load ALU write rw=5, aluout=0x1234 → next cycle WE=1, Rw=5, busW=0x00001234, Retired=1 one cycle later.
- Loads with memdata=0x80F17F02:
  - lb a=0 → 0xFFFFFF80
  - lbu a=0 → 0x00000080
  - lb a=2 → 0x0000007F
  - lh a=2 → 0x00007F02
  - lhu a=0 → 0x000080F1
  - lh a=1 → 0xFFFF80F1
  - lw → 0x80F17F02
- Write to $0: valid, regwrite=1, rw=0, aluout=0xDEADBEEF → WE=0, W_Valid=1, Retired increments.
- Stall/flush: load rw=7, then Stall=1 for 3 cycles → outputs held, Retired unchanged. Then Stall=1 & Flush=1 → next cycle WE=0, W_Valid=0, Retired+1.
- Link and bubble: wbsel=10, pclink=0x00400010, rw=31 → busW=0x00400010, WE=1. Then M_Valid=0, regwrite=1 → WE=0, Retired unchanged.
- Counter wrap with CNT_W=4: 17 valid unstalled instructions → Retired=1.
